// File: rtl/onchip_mem_byte_loader.sv
// rtl/onchip_mem_byte_loader.sv - packs a byte stream little-endian into 32-bit on-chip memory writes
module onchip_mem_byte_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 51200,
    parameter int CNT_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [CNT_WIDTH-1:0]  byte_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  bytes_written
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  written;
    logic [31:0]           pack_data;
    logic [3:0]            pack_be;
    logic [1:0]            lane;
    logic                  err_q;
    logic                  accept;
    logic                  base_bad;

    // A byte is taken only while filling; in_ready is a pure decode of FILL
    assign accept   = (state == FILL) && in_valid;
    assign base_bad = (base_address > LAST_ADDR);

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort outranks start, and a WRITE always finishes its cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !abort && !base_bad) begin
                    state_next = (byte_count == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && (lane == 2'd3 || remaining == CNT_WIDTH'(1))) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (remaining == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = FILL;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: transfer setup, byte-lane packing, and per-word commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_addr <= '0;
            remaining <= '0;
            written   <= '0;
            pack_data <= '0;
            pack_be   <= '0;
            lane      <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (base_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            word_addr <= base_address;
                            remaining <= byte_count;
                            written   <= '0;
                            pack_data <= '0;
                            pack_be   <= '0;
                            lane      <= '0;
                        end
                    end
                end
                FILL: begin
                    if (abort) begin
                        pack_data <= '0;
                        pack_be   <= '0;
                        lane      <= '0;
                    end else if (accept) begin
                        pack_data[{lane, 3'b000} +: 8] <= in_data;
                        pack_be[lane]                  <= 1'b1;
                        lane                           <= lane + 2'd1;
                        remaining                      <= remaining - CNT_WIDTH'(1);
                    end
                end
                WRITE: begin
                    written   <= written + {{(CNT_WIDTH-3){1'b0}}, popcount4(pack_be)};
                    word_addr <= (word_addr == LAST_ADDR) ? '0 : word_addr + ADDR_WIDTH'(1);
                    pack_data <= '0;
                    pack_be   <= '0;
                    lane      <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state and datapath only; idle memory bus is held at 0
    always_comb begin
        in_ready       = (state == FILL);
        busy           = (state == FILL) || (state == WRITE);
        mem_chipselect = (state == WRITE);
        mem_write      = (state == WRITE);
        mem_address    = (state == WRITE) ? word_addr : '0;
        mem_writedata  = (state == WRITE) ? pack_data : '0;
        mem_byteenable = (state == WRITE) ? pack_be   : '0;
        done           = (state == DONE);
        err            = err_q;
        bytes_written  = written;
    end

endmodule

// File: tb/tb_onchip_mem_byte_loader.sv
// tb/tb_onchip_mem_byte_loader.sv - scoreboard bench for onchip_mem_byte_loader
`timescale 1ns/1ps
module tb_onchip_mem_byte_loader;

    localparam int AW    = 16;
    localparam int DEPTH = 51200;
    localparam int CW    = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [CW-1:0] byte_count = '0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] bytes_written;

    onchip_mem_byte_loader #(
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .base_address(base_address),
        .byte_count(byte_count),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_address(mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect),
        .mem_write(mem_write),
        .mem_writedata(mem_writedata),
        .busy(busy),
        .done(done),
        .err(err),
        .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int write_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic [3:0]    exp_be[$];
    logic [7:0]    stim[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference model: word w of the image lands at (base + w) mod DEPTH, byte i in lane i%4
    task automatic model_push(input int base, input int n);
        int nwords;
        nwords = (n + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] d;
            logic [3:0]  b;
            d = 0;
            b = 0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) begin
                    d = d | (32'(stim[4 * w + k]) << (8 * k));
                    b = b | 4'(1 << k);
                end
            end
            exp_addr.push_back(AW'((base + w) % DEPTH));
            exp_data.push_back(d);
            exp_be.push_back(b);
        end
    endtask

    task automatic clear_expect();
        exp_addr.delete();
        exp_data.delete();
        exp_be.delete();
    endtask

    // Monitor: compares every memory write against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_write) begin
                    write_cnt++;
                    check("write_in_ready_low", in_ready, 0);
                    check("write_chipselect", mem_chipselect, 1);
                    check("write_busy", busy, 1);
                    if (exp_addr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write",
                                 mem_address, mem_writedata);
                    end else begin
                        check("write_addr", mem_address, exp_addr.pop_front());
                        check("write_data", mem_writedata, exp_data.pop_front());
                        check("write_be", mem_byteenable, exp_be.pop_front());
                    end
                end
                if (done) done_cnt++;
                if (err) err_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input int base, input int count);
        base_address = AW'(base);
        byte_count   = CW'(count);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Feeds stim[from..to-1]; an attempt counts only if in_ready was high across the edge
    task automatic send_range(input int from, input int to, input int gap_max);
        int idx;
        int guard;
        bit acc;
        idx = from;
        guard = 0;
        while (idx < to && guard < 500) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                in_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = stim[idx];
            acc      = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 500) check("send_timeout", idx, to);
    endtask

    task automatic wait_done(output bit found, output bit prev_write);
        bit pw;
        found = 0;
        pw = 0;
        prev_write = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                prev_write = pw;
                break;
            end
            pw = mem_write;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_full(input string tag, input int base, input int count, input int gap_max,
                            input bit random_data);
        int w0;
        bit found;
        bit pw;
        if (random_data) begin
            stim.delete();
            for (int i = 0; i < count; i++) stim.push_back(8'($urandom));
        end
        model_push(base, count);
        w0 = write_cnt;
        start_xfer(base, count);
        check({tag, "_busy"}, busy, 1);
        send_range(0, count, gap_max);
        wait_done(found, pw);
        check({tag, "_done_seen"}, found, 1);
        if (count > 0) check({tag, "_done_after_write"}, pw, 1);
        check({tag, "_bytes_written"}, bytes_written, count);
        check({tag, "_write_cycles"}, write_cnt - w0, (count + 3) / 4);
        check({tag, "_scoreboard_empty"}, exp_addr.size(), 0);
        clear_expect();
    endtask

    initial begin
        int w0;
        int d0;
        int e0;
        bit found;
        bit pw;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_bytes_written", bytes_written, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_mem_chipselect", mem_chipselect, 0);
        check("idle_writedata", mem_writedata, 0);

        // Directed 6-byte load with the known image
        stim.delete();
        for (int i = 1; i <= 6; i++) stim.push_back(8'(i * 8'h11));
        run_full("six_bytes", 16'h0010, 6, 0, 1'b0);

        // Address wrap at the top of memory
        run_full("wrap", DEPTH - 1, 8, 0, 1'b1);

        // Gapped input must give the same writes as gap-free
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back(8'($urandom));
        run_full("five_gapfree", 16'h0200, 5, 0, 1'b0);
        run_full("five_gapped", 16'h0200, 5, 3, 1'b0);

        // Random transfers
        for (int t = 0; t < 6; t++) begin
            int b;
            b = (t % 2 == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(DEPTH - 3, DEPTH - 1));
            run_full("random", b, int'($urandom_range(1, 13)), int'($urandom_range(0, 2)), 1'b1);
        end

        // Zero-length start: done next cycle, no write
        w0 = write_cnt;
        start_xfer(16'h0040, 0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_bytes_written", bytes_written, 0);
        @(posedge clk);
        #1;
        check("zero_idle", busy, 0);
        check("zero_no_write", write_cnt - w0, 0);

        // Out-of-range base: err pulse only
        w0 = write_cnt;
        e0 = err_cnt;
        start_xfer(DEPTH, 8);
        check("badbase_err", err, 1);
        check("badbase_busy", busy, 0);
        @(posedge clk);
        #1;
        check("badbase_err_one_cycle", err, 0);
        check("badbase_err_count", err_cnt - e0, 1);
        check("badbase_no_write", write_cnt - w0, 0);

        // Abort after two bytes: nothing written, no done
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
        w0 = write_cnt;
        d0 = done_cnt;
        start_xfer(16'h0300, 8);
        send_range(0, 2, 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_write", write_cnt - w0, 0);
        check("abort_no_done", done_cnt - d0, 0);

        // start while busy is ignored
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
        model_push(16'h0100, 8);
        w0 = write_cnt;
        e0 = err_cnt;
        start_xfer(16'h0100, 8);
        send_range(0, 2, 0);
        start_xfer(16'h0500, 4);
        send_range(2, 8, 0);
        wait_done(found, pw);
        check("busy_start_done", found, 1);
        check("busy_start_bytes", bytes_written, 8);
        check("busy_start_writes", write_cnt - w0, 2);
        check("busy_start_no_err", err_cnt - e0, 0);
        check("busy_start_scoreboard_empty", exp_addr.size(), 0);
        clear_expect();

        // Reset landing in a WRITE cycle
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
        start_xfer(16'h0700, 8);
        send_range(0, 4, 0);
        check("prereset_write", mem_write, 1);
        reset = 1'b1;
        #1;
        check("reset_mem_write", mem_write, 0);
        check("reset_chipselect", mem_chipselect, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_writedata", mem_writedata, 0);
        check("reset_bytes_written", bytes_written, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", busy, 0);

        // Loader usable again after reset
        run_full("after_reset", 16'h0020, 7, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
